// File: rtl/softmax_fx_engine.sv
// Fixed-point softmax over N_CLASS logits with argmax; max scan, base-2 exp LUT, shared restoring divider.
// Latency: valid_out rises 2*N_CLASS + N_CLASS*(OUT_W+1) + 1 cycles after the accept edge.
// Backpressure: result held while valid_out && !ready_out; ready_in only in IDLE, busy-time valid_in ignored.
module softmax_fx_engine #(
    parameter int N_CLASS = 10,
    parameter int IN_W    = 16,
    parameter int IN_FRAC = 8,
    parameter int OUT_W   = 16,
    parameter int LUT_AW  = 8
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         valid_in,
    output logic                         ready_in,
    input  logic [N_CLASS*IN_W-1:0]      d_in,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic [N_CLASS*OUT_W-1:0]     percent,
    output logic [$clog2(N_CLASS)-1:0]   argmax
);

    localparam int IDX_W = $clog2(N_CLASS);
    localparam int E_W   = OUT_W + 1;
    localparam int S_W   = E_W + $clog2(N_CLASS);
    localparam int D_W   = IN_W + 1;
    localparam int P_W   = D_W + 16;
    localparam int T_W   = P_W - 15;
    localparam int K_W   = T_W - IN_FRAC;
    localparam int BC_W  = $clog2(OUT_W + 1);
    localparam logic [15:0] LOG2E_Q15 = 16'd47274;

    typedef enum logic [2:0] {
        IDLE,
        MAX,
        EXP,
        DIV,
        DONE
    } state_t;

    state_t state, state_nxt;

    // 2^(-f/2^LUT_AW) scaled to 2^OUT_W, evaluated at elaboration only
    function automatic logic [E_W-1:0] lut_val(input int f);
        real v;
        v = (2.0 ** (-real'(f) / real'(2 ** LUT_AW))) * (2.0 ** OUT_W);
        return E_W'($rtoi(v + 0.5));
    endfunction

    logic [E_W-1:0] lut_rom [2**LUT_AW];

    for (genvar g = 0; g < 2**LUT_AW; g++) begin : g_lut
        localparam logic [E_W-1:0] LV = lut_val(g);
        assign lut_rom[g] = LV;
    end

    logic signed [IN_W-1:0] x_buf [N_CLASS];
    logic [E_W-1:0]         e_buf [N_CLASS];
    logic [OUT_W-1:0]       p_buf [N_CLASS];

    logic signed [IN_W-1:0] max_r;
    logic [IDX_W-1:0]       arg_r;
    logic [IDX_W-1:0]       idx;
    logic [BC_W-1:0]        bcnt;
    logic [S_W-1:0]         sum_r;
    logic [S_W-1:0]         rem;
    logic [OUT_W-1:0]       quo;

    logic                   last_idx;
    logic                   last_bit;
    logic signed [IN_W-1:0] x_cur;
    logic signed [D_W-1:0]  dm;
    logic signed [D_W-1:0]  dx;
    logic [D_W-1:0]         d;
    logic [P_W-1:0]         prod;
    logic [T_W-1:0]         t;
    logic [K_W-1:0]         k;
    logic [LUT_AW-1:0]      f;
    logic [E_W-1:0]         e_cur;
    logic [S_W:0]           rem_sh;
    logic [S_W:0]           sum_ext;
    logic                   qbit;
    logic [S_W-1:0]         rem_nxt;

    assign ready_in = (state == IDLE);
    assign last_idx = (idx == IDX_W'(N_CLASS - 1));
    assign last_bit = (bcnt == BC_W'(OUT_W));

    // exp(-d) = 2^-(d*log2e): integer part shifts, fraction indexes the LUT
    always_comb begin
        x_cur = x_buf[idx];
        dm    = D_W'(max_r);
        dx    = D_W'(x_cur);
        d     = dm - dx;
        prod  = P_W'(d) * P_W'(LOG2E_Q15);
        t     = T_W'(prod >> 15);
        k     = t[T_W-1:IN_FRAC];
        f     = t[IN_FRAC-1 -: LUT_AW];
        e_cur = '0;
        if (k <= K_W'(OUT_W)) begin
            e_cur = lut_rom[f] >> k;
        end
    end

    // one restoring step; rem == sum (e == sum) yields all-ones, i.e. saturation
    always_comb begin
        rem_sh  = {rem, 1'b0};
        sum_ext = {1'b0, sum_r};
        qbit    = (rem_sh >= sum_ext);
        rem_nxt = qbit ? S_W'(rem_sh - sum_ext) : S_W'(rem_sh);
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (valid_in) state_nxt = MAX;
            MAX:  if (last_idx) state_nxt = EXP;
            EXP:  if (last_idx) state_nxt = DIV;
            DIV:  if (last_idx && last_bit) state_nxt = DONE;
            DONE: if (valid_out && ready_out) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            for (int i = 0; i < N_CLASS; i++) begin
                x_buf[i] <= '0;
                e_buf[i] <= '0;
                p_buf[i] <= '0;
            end
            max_r     <= '0;
            arg_r     <= '0;
            idx       <= '0;
            bcnt      <= '0;
            sum_r     <= '0;
            rem       <= '0;
            quo       <= '0;
            valid_out <= 1'b0;
            percent   <= '0;
            argmax    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (valid_in) begin
                        for (int i = 0; i < N_CLASS; i++) begin
                            x_buf[i] <= d_in[i*IN_W +: IN_W];
                        end
                        max_r <= d_in[IN_W-1:0];
                        arg_r <= '0;
                        idx   <= '0;
                        bcnt  <= '0;
                        sum_r <= '0;
                    end
                end
                MAX: begin
                    // strictly greater keeps the lowest index on ties
                    if (x_cur > max_r) begin
                        max_r <= x_cur;
                        arg_r <= idx;
                    end
                    idx <= last_idx ? '0 : idx + 1'b1;
                end
                EXP: begin
                    e_buf[idx] <= e_cur;
                    sum_r      <= sum_r + S_W'(e_cur);
                    idx        <= last_idx ? '0 : idx + 1'b1;
                end
                DIV: begin
                    if (bcnt == '0) begin
                        rem  <= S_W'(e_buf[idx]);
                        quo  <= '0;
                        bcnt <= bcnt + 1'b1;
                    end else begin
                        rem <= rem_nxt;
                        quo <= {quo[OUT_W-2:0], qbit};
                        if (last_bit) begin
                            p_buf[idx] <= {quo[OUT_W-2:0], qbit};
                            bcnt       <= '0;
                            idx        <= last_idx ? '0 : idx + 1'b1;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!valid_out) begin
                        valid_out <= 1'b1;
                        argmax    <= arg_r;
                        for (int i = 0; i < N_CLASS; i++) begin
                            percent[i*OUT_W +: OUT_W] <= p_buf[i];
                        end
                    end else if (ready_out) begin
                        valid_out <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_fx_engine.sv
// Directed bench for softmax_fx_engine: default 10-class build plus a 2-class build,
// hand-computed probabilities, latency, tie, saturation, backpressure and abort-by-reset.
module tb_softmax_fx_engine;

    logic         clk;
    logic         resetn;

    logic         valid_in, ready_in, valid_out, ready_out;
    logic [159:0] d_in;
    logic [159:0] percent;
    logic [3:0]   argmax;

    logic         valid_in2, ready_in2, valid_out2, ready_out2;
    logic [31:0]  d_in2;
    logic [31:0]  percent2;
    logic [0:0]   argmax2;

    int n_cmp = 0;
    int n_mis = 0;

    softmax_fx_engine dut (
        .clk       (clk),
        .resetn    (resetn),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .d_in      (d_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .percent   (percent),
        .argmax    (argmax)
    );

    softmax_fx_engine #(.N_CLASS(2)) dut2 (
        .clk       (clk),
        .resetn    (resetn),
        .valid_in  (valid_in2),
        .ready_in  (ready_in2),
        .d_in      (d_in2),
        .valid_out (valid_out2),
        .ready_out (ready_out2),
        .percent   (percent2),
        .argmax    (argmax2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // present a vector, wait for accept, then count cycles until valid_out
    task automatic run_vec(input bit use2, input logic [159:0] v, output int lat);
        int n;
        @(negedge clk);
        if (use2) begin
            d_in2 = v[31:0];
            valid_in2 = 1'b1;
        end else begin
            d_in = v;
            valid_in = 1'b1;
        end
        n = 0;
        while (!(use2 ? ready_in2 : ready_in) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (use2) valid_in2 = 1'b0;
        else valid_in = 1'b0;
        lat = 0;
        while (!(use2 ? valid_out2 : valid_out) && lat < 600) begin
            @(negedge clk);
            lat++;
        end
    endtask

    logic [159:0] v;
    logic [159:0] hold_pct;
    int lat;
    int errs;

    initial begin
        resetn     = 1'b1;
        valid_in   = 1'b0;
        ready_out  = 1'b1;
        d_in       = '0;
        valid_in2  = 1'b0;
        ready_out2 = 1'b1;
        d_in2      = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);

        chk("rst_ready_in", ready_in, 1);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_percent", percent, 0);
        chk("rst_argmax", argmax, 0);
        chk("rst_ready_in2", ready_in2, 1);

        // all logits 1.0: uniform distribution
        for (int i = 0; i < 10; i++) v[i*16 +: 16] = 16'h0100;
        run_vec(1'b0, v, lat);
        chk("uni_latency", lat, 191);
        for (int i = 0; i < 10; i++) chk($sformatf("uni_p%0d", i), percent[i*16 +: 16], 6553);
        chk("uni_argmax", argmax, 0);

        // one dominant class: others flush to zero, winner saturates
        v = '0;
        v[15:0] = 16'h1400;
        run_vec(1'b0, v, lat);
        chk("dom_p0", percent[15:0], 16'hFFFF);
        for (int i = 1; i < 10; i++) chk($sformatf("dom_p%0d", i), percent[i*16 +: 16], 0);
        chk("dom_argmax", argmax, 0);

        // tie between classes 3 and 7
        for (int i = 0; i < 10; i++) v[i*16 +: 16] = 16'hF800;
        v[3*16 +: 16] = 16'h0500;
        v[7*16 +: 16] = 16'h0500;
        run_vec(1'b0, v, lat);
        chk("tie_p3", percent[3*16 +: 16], 32768);
        chk("tie_p7", percent[7*16 +: 16], 32768);
        chk("tie_p0", percent[15:0], 0);
        chk("tie_argmax", argmax, 3);

        // two-class build: 0 vs -1.0
        v = '0;
        v[31:16] = 16'hFF00;
        run_vec(1'b1, v, lat);
        chk("n2_latency", lat, 39);
        chk("n2_p0", percent2[15:0], 47899);
        chk("n2_p1", percent2[31:16], 17636);
        chk("n2_argmax", argmax2, 0);

        // two-class extreme span: most-negative vs most-positive
        v = '0;
        v[15:0]  = 16'h8000;
        v[31:16] = 16'h7FFF;
        run_vec(1'b1, v, lat);
        chk("ext_p0", percent2[15:0], 0);
        chk("ext_p1", percent2[31:16], 16'hFFFF);
        chk("ext_argmax", argmax2, 1);

        // backpressure: hold the uniform result 20 cycles with a new vector pending
        ready_out = 1'b0;
        for (int i = 0; i < 10; i++) v[i*16 +: 16] = 16'h0100;
        run_vec(1'b0, v, lat);
        chk("bp_latency", lat, 191);
        hold_pct = '0;
        for (int i = 0; i < 10; i++) hold_pct[i*16 +: 16] = 16'd6553;
        v = '0;
        v[5*16 +: 16] = 16'h0100;
        d_in = v;
        valid_in = 1'b1;
        errs = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (valid_out !== 1'b1 || ready_in !== 1'b0 || percent !== hold_pct || argmax !== 4'd0) errs++;
        end
        chk("bp_hold_errs", errs, 0);
        ready_out = 1'b1;
        @(negedge clk);
        chk("bp_xfer_valid_out", valid_out, 0);
        chk("bp_xfer_ready_in", ready_in, 1);
        @(negedge clk);
        valid_in = 1'b0;
        lat = 0;
        while (!valid_out && lat < 600) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_next_latency", lat, 191);
        chk("bp_next_p5", percent[5*16 +: 16], 15191);
        chk("bp_next_p0", percent[15:0], 5593);
        chk("bp_next_p9", percent[9*16 +: 16], 5593);
        chk("bp_next_argmax", argmax, 5);

        // reset in the middle of DIV aborts the vector
        @(negedge clk);
        for (int i = 0; i < 10; i++) v[i*16 +: 16] = 16'h0100;
        d_in = v;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (60) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        chk("abort_ready_in", ready_in, 1);
        chk("abort_percent", percent, 0);
        errs = 0;
        for (int c = 0; c < 250; c++) begin
            @(negedge clk);
            if (valid_out) errs++;
        end
        chk("abort_no_valid", errs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
